multicycle_ctrl: RTL
====================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter OP_W, default 6: opcode width, minimum 6; any nonzero bit above bit 5 makes the opcode illegal.
REQ-002 Parameter TIMEOUT, default 15: maximum cycles to wait on mem_ready before aborting, range 1..255.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 op  input  OP_W  opcode from the instruction register; stable from DECODE until return to FETCH.
REQ-006 mem_ready  input  1  memory access completes this cycle.
REQ-007 pcwrite  output  1  unconditional PC write.
REQ-008 branch  output  1  conditional PC write, qualified by the datapath.
REQ-009 brle  output  1  branch condition select: 0 = equal, 1 = less-or-equal.
REQ-010 iord  output  1  memory address select: 0 = PC, 1 = ALU result.
REQ-011 irwrite  output  1  instruction register load.
REQ-012 memwrite  output  1  data memory write strobe.
REQ-013 memwidth  output  2  store width: 00 = byte, 01 = half (reserved), 10 = word.
REQ-014 memtoreg  output  1  register write-back source: 1 = memory data.
REQ-015 regdst  output  1  destination register: 1 = rd, 0 = rt.
REQ-016 regwrite  output  1  register file write enable.
REQ-017 alusrca  output  1  ALU A operand: 0 = PC, 1 = register A.
REQ-018 alusrcb  output  2  ALU B operand: 00 = register B, 01 = 4, 10 = sign-extended immediate, 11 = shifted immediate.
REQ-019 pcsrc  output  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target.
REQ-020 aluop  output  2  ALU class: 00 = add, 01 = subtract/compare, 10 = funct field, 11 = pass immediate.
REQ-021 illegal_op  output  1  one-cycle pulse when an undefined opcode is decoded.
REQ-022 mem_timeout  output  1  one-cycle pulse when a memory wait is aborted.

Function
REQ-023 The block SHALL be a Moore FSM, with mem_ready gating only as stated below; any output not listed for a state SHALL be 0 (never x); memwidth SHALL be 10 except where stated.
REQ-024 Opcodes SHALL be: RTYPE 000000, LW 100011, SW 101011, SB 101000, BEQ 000100, BLE 011111, ADDI 001000, J 000010, LI 010001.
REQ-025 FETCH: alusrcb=01, irwrite=pcwrite=mem_ready; it SHALL advance to DECODE only when mem_ready=1.
REQ-026 DECODE: alusrcb=11. Next state by opcode: LW/SW/SB -> MEMADR; RTYPE -> RTEXEC; BEQ -> BEQ; BLE -> BLE; ADDI -> ADDIEX; J -> JUMP; LI -> LIEX. Any other opcode SHALL pulse illegal_op and go to FETCH.
REQ-027 MEMADR: alusrca=1, alusrcb=10. Next state: LW -> MEMRD; SW or SB -> MEMWR.
REQ-028 MEMRD: iord=1; it SHALL go to MEMWB on mem_ready=1. MEMWB: memtoreg=1, regwrite=1; then FETCH.
REQ-029 MEMWR: iord=1, memwrite=1, memwidth=00 for SB and 10 for SW; it SHALL go to FETCH on mem_ready=1.
REQ-030 RTEXEC: alusrca=1, aluop=10; then ALUWB. ALUWB: regdst=1, regwrite=1; then FETCH.
REQ-031 BEQ and BLE: alusrca=1, aluop=01, pcsrc=01, branch=1; brle=0 in BEQ and 1 in BLE; then FETCH.
REQ-032 ADDIEX: alusrca=1, alusrcb=10. LIEX: alusrcb=10, aluop=11. Both go to IMMWB. IMMWB: regwrite=1; then FETCH.
REQ-033 JUMP: pcsrc=10, pcwrite=1; then FETCH.
REQ-034 Wait counter: cleared on entry to FETCH, MEMRD or MEMWR; increments each cycle the block waits with mem_ready=0.
REQ-035 When the counter equals TIMEOUT and mem_ready=0, the block SHALL pulse mem_timeout, suppress irwrite/pcwrite/memwrite that cycle, and go to FETCH with the counter cleared.
REQ-036 mem_ready=1 in the cycle the counter reaches TIMEOUT SHALL complete normally, with no mem_timeout pulse.

Reset
REQ-037 reset=1 at a clock edge SHALL force state FETCH and clear the counter, from any state, including mid-wait.
REQ-038 While reset=1, all write enables, illegal_op and mem_timeout SHALL be 0 combinationally.

Configuration
REQ-039 With macro MCTRL_LI_EN defined, LI SHALL decode to LIEX; without it, LIEX SHALL not exist and opcode 010001 SHALL be illegal.

Structure
REQ-040 Package mctrl_pkg SHALL hold the state enum, opcode constants, and the aluop/alusrcb/pcsrc/memwidth encodings.
REQ-041 Sub-module mctrl_timer SHALL implement the wait counter and timeout compare.

Verification
REQ-042 LW with mem_ready held 1 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB over 5 cycles; regwrite=1 and memtoreg=1 in cycle 5.
REQ-043 SB then SW, mem_ready=1 -> in MEMWR, memwrite=1 with memwidth=00 for SB, then memwidth=10 for SW; 4 cycles each.
REQ-044 TIMEOUT=3, LW with mem_ready=0 in MEMRD -> mem_timeout pulses once on the 4th MEMRD cycle, regwrite never asserts, next state FETCH.
REQ-045 op=111111 -> illegal_op=1 for exactly the DECODE cycle; FETCH follows; no write enable asserts.
REQ-046 reset asserted during MEMWR with mem_ready=0 -> memwrite=0 in that cycle; FETCH after the edge; counter=0.

Source files
------------

// File: rtl/mctrl_pkg.sv
// Shared types and encodings for the multicycle controller.
// MCTRL_LI_EN adds the load-immediate (LI) execute state.
package mctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMRD,
      S_MEMWB,
      S_MEMWR,
      S_RTEXEC,
      S_ALUWB,
      S_BEQ,
      S_BLE,
      S_ADDIEX,
      S_IMMWB,
`ifdef MCTRL_LI_EN
      S_JUMP,
      S_LIEX
`else
      S_JUMP
`endif
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_SB    = 6'b101000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BLE   = 6'b011111;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_LI    = 6'b010001;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;
   localparam logic [1:0] ALU_PASS  = 2'b11;

   localparam logic [1:0] SRCB_REG   = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_SEXT  = 2'b10;
   localparam logic [1:0] SRCB_SHIFT = 2'b11;

   localparam logic [1:0] PC_ALU    = 2'b00;
   localparam logic [1:0] PC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;

   localparam logic [1:0] MW_BYTE = 2'b00;
   localparam logic [1:0] MW_HALF = 2'b01;
   localparam logic [1:0] MW_WORD = 2'b10;

endpackage

// File: rtl/mctrl_if.sv
// Opcode/ready inputs and datapath control outputs of the controller.
interface mctrl_if #(
   parameter int OP_W = 6
);
   logic [OP_W-1:0] op;
   logic            mem_ready;
   logic            pcwrite;
   logic            branch;
   logic            brle;
   logic            iord;
   logic            irwrite;
   logic            memwrite;
   logic [1:0]      memwidth;
   logic            memtoreg;
   logic            regdst;
   logic            regwrite;
   logic            alusrca;
   logic [1:0]      alusrcb;
   logic [1:0]      pcsrc;
   logic [1:0]      aluop;
   logic            illegal_op;
   logic            mem_timeout;

   modport master (
      output op, mem_ready,
      input  pcwrite, branch, brle, iord, irwrite, memwrite, memwidth,
      input  memtoreg, regdst, regwrite, alusrca, alusrcb, pcsrc, aluop,
      input  illegal_op, mem_timeout
   );

   modport slave (
      input  op, mem_ready,
      output pcwrite, branch, brle, iord, irwrite, memwrite, memwidth,
      output memtoreg, regdst, regwrite, alusrca, alusrcb, pcsrc, aluop,
      output illegal_op, mem_timeout
   );
endinterface

// File: rtl/mctrl_timer.sv
// Memory wait counter; flags expiry when a wait reaches TIMEOUT cycles.
module mctrl_timer #(
   parameter int TIMEOUT = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic wait_en,
   output logic expired
);
   localparam logic [7:0] LIM = 8'(TIMEOUT);

   logic [7:0] cnt;

   assign expired = wait_en && (cnt == LIM);

   always_ff @(posedge clk) begin
      if (reset || clr || expired)
         cnt <= '0;
      else if (wait_en)
         cnt <= cnt + 8'd1;
   end
endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for a multicycle CPU with memory-wait timeout.
// MCTRL_LI_EN enables the LI opcode; otherwise LI decodes as illegal.
module multicycle_ctrl
   import mctrl_pkg::*;
#(
   parameter int OP_W    = 6,
   parameter int TIMEOUT = 15
) (
   input logic    clk,
   input logic    reset,
   mctrl_if.slave bus
);
   state_t     state, nxt;
   logic [5:0] op6;
   logic       hi_ok, waiting, expired, clr, illegal;
   logic       pcw, irw, mw, rw, br;

   assign op6   = bus.op[5:0];
   assign hi_ok = (bus.op >> 6) == '0;

   assign waiting = !bus.mem_ready &&
      (state == S_FETCH || state == S_MEMRD || state == S_MEMWR);

   // Counter restarts whenever a wait state is freshly entered
   assign clr = (nxt != state) &&
      (nxt == S_FETCH || nxt == S_MEMRD || nxt == S_MEMWR);

   mctrl_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk     (clk),
      .reset   (reset),
      .clr     (clr),
      .wait_en (waiting),
      .expired (expired)
   );

   always_comb begin
      nxt     = state;
      illegal = 1'b0;
      unique case (state)
         S_FETCH:
            if (bus.mem_ready) nxt = S_DECODE;
         S_DECODE: begin
            nxt = S_FETCH;
            if (!hi_ok) illegal = 1'b1;
            else begin
               case (op6)
                  OP_LW, OP_SW, OP_SB: nxt = S_MEMADR;
                  OP_RTYPE:            nxt = S_RTEXEC;
                  OP_BEQ:              nxt = S_BEQ;
                  OP_BLE:              nxt = S_BLE;
                  OP_ADDI:             nxt = S_ADDIEX;
                  OP_J:                nxt = S_JUMP;
`ifdef MCTRL_LI_EN
                  OP_LI:               nxt = S_LIEX;
`endif
                  default:             illegal = 1'b1;
               endcase
            end
         end
         S_MEMADR:
            nxt = (op6 == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:
            if (expired) nxt = S_FETCH;
            else if (bus.mem_ready) nxt = S_MEMWB;
         S_MEMWR:
            if (expired || bus.mem_ready) nxt = S_FETCH;
         S_RTEXEC: nxt = S_ALUWB;
         S_ADDIEX: nxt = S_IMMWB;
`ifdef MCTRL_LI_EN
         S_LIEX:   nxt = S_IMMWB;
`endif
         default:  nxt = S_FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= S_FETCH;
      else       state <= nxt;
   end

   always_comb begin
      pcw          = 1'b0;
      irw          = 1'b0;
      mw           = 1'b0;
      rw           = 1'b0;
      br           = 1'b0;
      bus.brle     = 1'b0;
      bus.iord     = 1'b0;
      bus.memwidth = MW_WORD;
      bus.memtoreg = 1'b0;
      bus.regdst   = 1'b0;
      bus.alusrca  = 1'b0;
      bus.alusrcb  = SRCB_REG;
      bus.pcsrc    = PC_ALU;
      bus.aluop    = ALU_ADD;
      unique case (state)
         S_FETCH: begin
            bus.alusrcb = SRCB_FOUR;
            irw         = bus.mem_ready;
            pcw         = bus.mem_ready;
         end
         S_DECODE: bus.alusrcb = SRCB_SHIFT;
         S_MEMADR: begin
            bus.alusrca = 1'b1;
            bus.alusrcb = SRCB_SEXT;
         end
         S_MEMRD: bus.iord = 1'b1;
         S_MEMWB: begin
            bus.memtoreg = 1'b1;
            rw           = 1'b1;
         end
         S_MEMWR: begin
            bus.iord     = 1'b1;
            mw           = !expired;
            bus.memwidth = (op6 == OP_SB) ? MW_BYTE : MW_WORD;
         end
         S_RTEXEC: begin
            bus.alusrca = 1'b1;
            bus.aluop   = ALU_FUNCT;
         end
         S_ALUWB: begin
            bus.regdst = 1'b1;
            rw         = 1'b1;
         end
         S_BEQ, S_BLE: begin
            bus.alusrca = 1'b1;
            bus.aluop   = ALU_SUB;
            bus.pcsrc   = PC_ALUOUT;
            br          = 1'b1;
            bus.brle    = (state == S_BLE);
         end
         S_ADDIEX: begin
            bus.alusrca = 1'b1;
            bus.alusrcb = SRCB_SEXT;
         end
`ifdef MCTRL_LI_EN
         S_LIEX: begin
            bus.alusrcb = SRCB_SEXT;
            bus.aluop   = ALU_PASS;
         end
`endif
         S_IMMWB: rw = 1'b1;
         S_JUMP: begin
            bus.pcsrc = PC_JUMP;
            pcw       = 1'b1;
         end
         default: ;
      endcase
   end

   assign bus.pcwrite     = pcw && !reset;
   assign bus.irwrite     = irw && !reset;
   assign bus.memwrite    = mw && !reset;
   assign bus.regwrite    = rw && !reset;
   assign bus.branch      = br && !reset;
   assign bus.illegal_op  = illegal && !reset;
   assign bus.mem_timeout = expired && !reset;
endmodule
